// File: rtl/comp_sign_seq_if.sv
// Handshake and operand bundle for the sequential magnitude comparator.
// The master side issues operands and start; the slave side returns status and flags.
interface comp_sign_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic             Gt;
  logic             Eq;
  logic             Lt;

  modport master (
    output start, signed_mode, A, B,
    input  busy, done, Gt, Eq, Lt
  );

  modport slave (
    input  start, signed_mode, A, B,
    output busy, done, Gt, Eq, Lt
  );
endinterface

// File: rtl/comp_sign_seq.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per clock, with
// early exit on the first differing digit and signed/unsigned selection.
module comp_sign_seq #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input logic            clk,
  input logic            rst,
  comp_sign_seq_if.slave bus
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             done_q, done_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;

  logic [DIGIT-1:0] a_dig [NDIG];
  logic [DIGIT-1:0] b_dig [NDIG];

  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_dig
      assign a_dig[gi] = a_q[gi*DIGIT +: DIGIT];
      assign b_dig[gi] = b_q[gi*DIGIT +: DIGIT];
    end
  endgenerate

  logic [DIGIT-1:0] a_cur;
  logic [DIGIT-1:0] b_cur;
  assign a_cur = a_dig[idx_q];
  assign b_cur = b_dig[idx_q];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    gt_d    = gt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          // Flipping both MSBs maps two's-complement order onto unsigned order.
          a_d     = bus.signed_mode ? (bus.A ^ MSB_MASK) : bus.A;
          b_d     = bus.signed_mode ? (bus.B ^ MSB_MASK) : bus.B;
          idx_d   = IDXW'(NDIG - 1);
          gt_d    = 1'b0;
          eq_d    = 1'b0;
          lt_d    = 1'b0;
          state_d = S_RUN;
        end
      end
      default: begin
        if (a_cur != b_cur) begin
          gt_d    = (a_cur > b_cur);
          lt_d    = (a_cur < b_cur);
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (idx_q == '0) begin
          eq_d    = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          idx_d   = idx_q - IDXW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
    end
  end

  assign bus.busy = (state_q == S_RUN);
  assign bus.done = done_q;
  assign bus.Gt   = gt_q;
  assign bus.Eq   = eq_q;
  assign bus.Lt   = lt_q;
endmodule

// File: tb/tb_comp_sign_seq.sv
// Directed bench for comp_sign_seq: a latency/result model checked every cycle
// plus literal expectations for each scenario.
module tb_comp_sign_seq;
  localparam int W  = 8;
  localparam int D  = 2;
  localparam int ND = W / D;

  localparam int R_LT = 0;
  localparam int R_EQ = 1;
  localparam int R_GT = 2;

  logic clk;
  logic rst;
  comp_sign_seq_if #(.WIDTH(W)) bus ();

  comp_sign_seq #(.WIDTH(W), .DIGIT(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Result from plain integer ordering of the operands.
  function automatic int model_res(input bit sm, input logic [W-1:0] a, input logic [W-1:0] b);
    int ai;
    int bi;
    ai = sm ? int'({{(32-W){a[W-1]}}, a}) : int'({{(32-W){1'b0}}, a});
    bi = sm ? int'({{(32-W){b[W-1]}}, b}) : int'({{(32-W){1'b0}}, b});
    if (ai > bi) return R_GT;
    if (ai == bi) return R_EQ;
    return R_LT;
  endfunction

  // Latency = length (in digits) of the shortest differing MSB prefix.
  function automatic int model_lat(input logic [W-1:0] a, input logic [W-1:0] b);
    for (int k = 1; k <= ND; k++) begin
      if ((a >> (W - k*D)) != (b >> (W - k*D))) return k;
    end
    return ND;
  endfunction

  logic m_busy, m_done, m_gt, m_eq, m_lt;
  int   m_rem;
  int   m_res;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_gt   <= 1'b0;
      m_eq   <= 1'b0;
      m_lt   <= 1'b0;
      m_rem  <= 0;
      m_res  <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_gt   <= (m_res == R_GT);
          m_eq   <= (m_res == R_EQ);
          m_lt   <= (m_res == R_LT);
        end
      end else if (bus.start) begin
        m_busy <= 1'b1;
        m_rem  <= model_lat(bus.A, bus.B);
        m_res  <= model_res(bus.signed_mode, bus.A, bus.B);
        m_gt   <= 1'b0;
        m_eq   <= 1'b0;
        m_lt   <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", int'(bus.busy), int'(m_busy));
    chk("done", int'(bus.done), int'(m_done));
    chk("gt",   int'(bus.Gt),   int'(m_gt));
    chk("eq",   int'(bus.Eq),   int'(m_eq));
    chk("lt",   int'(bus.Lt),   int'(m_lt));
  end

  // Waits for done after an accept; cnt = edges from accept to done.
  task automatic wait_done(output int cnt);
    cnt = 0;
    @(negedge clk);
    while (!bus.done && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic run(input string name, input bit sm, input logic [W-1:0] a,
                     input logic [W-1:0] b, input int exp_res, input int exp_lat,
                     input bit disturb);
    int cnt;
    chk({name, "_model_res"}, model_res(sm, a, b), exp_res);
    chk({name, "_model_lat"}, model_lat(a, b), exp_lat);
    bus.signed_mode = sm;
    bus.A = a;
    bus.B = b;
    bus.start = 1'b1;
    wait_done(cnt);
    bus.start = 1'b0;
    if (disturb) begin
      bus.A = '0;
      bus.signed_mode = ~sm;
    end
    chk({name, "_lat"}, cnt, exp_lat);
    chk({name, "_gt"}, int'(bus.Gt), int'(exp_res == R_GT));
    chk({name, "_eq"}, int'(bus.Eq), int'(exp_res == R_EQ));
    chk({name, "_lt"}, int'(bus.Lt), int'(exp_res == R_LT));
    $display("txn %s sm=%0d A=%02h B=%02h lat=%0d G/E/L=%0d%0d%0d",
             name, sm, a, b, cnt, bus.Gt, bus.Eq, bus.Lt);
  endtask

  int cnt_bb;
  int done_seen;

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.signed_mode = 1'b0;
    bus.A = '0;
    bus.B = '0;
    @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_flags", int'({bus.Gt, bus.Eq, bus.Lt}), 0);
    rst = 1'b0;
    @(negedge clk);

    run("s_1_vs_m1",   1'b1, 8'h01, 8'hFF, R_GT, 1, 1'b0);
    run("u_1_vs_255",  1'b0, 8'h01, 8'hFF, R_LT, 1, 1'b0);
    run("s_m2_vs_m1",  1'b1, 8'hFE, 8'hFF, R_LT, 4, 1'b1);
    run("u_34_vs_30",  1'b0, 8'h34, 8'h30, R_GT, 3, 1'b0);
    run("u_9c_eq",     1'b0, 8'h9C, 8'h9C, R_EQ, 4, 1'b0);
    run("s_min_vs_max", 1'b1, 8'h80, 8'h7F, R_LT, 1, 1'b0);

    // Back-to-back: start held high re-accepts in each done cycle.
    bus.signed_mode = 1'b1;
    bus.A = 8'h81;
    bus.B = 8'h81;
    bus.start = 1'b1;
    for (int r = 0; r < 3; r++) begin
      wait_done(cnt_bb);
      chk("b2b_lat", cnt_bb, 4);
      chk("b2b_eq", int'(bus.Eq), 1);
      chk("b2b_busy", int'(bus.busy), 0);
      $display("txn b2b rep=%0d lat=%0d Eq=%0d", r, cnt_bb, bus.Eq);
    end
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Abort a compare with reset asserted around the 2nd RUN edge.
    bus.signed_mode = 1'b1;
    bus.A = 8'hFE;
    bus.B = 8'hFF;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_done", int'(bus.done), 0);
    chk("abort_flags", int'({bus.Gt, bus.Eq, bus.Lt}), 0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    chk("abort_no_done", done_seen, 0);
    $display("txn abort done_seen=%0d", done_seen);

    run("after_abort", 1'b1, 8'hFE, 8'hFF, R_LT, 4, 1'b0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
